uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO. It serialises words from the FIFO onto the `uart_tx` line. It replaces the fixed 8N1 transmit path that drives the top-level `uart_tx` pin. Data width, stop-bit count, baud divider and FIFO depth are all configurable, and an optional parity bit can be compiled in. The CPU side writes words with a single-cycle strobe; the block frames and sends them back-to-back with no idle gap while the FIFO holds data.

Parameters:
- CLK_DIV, 4: clk cycles per UART bit. Legal values are 2 and above.
- DATA_BITS, 8: payload bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits per frame. Legal values 1 or 2.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of 2, 2 or more. CW = log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe; one word per cycle.
- wr_data  in  DATA_BITS  word to enqueue.
- full  out  1  FIFO holds FIFO_DEPTH words.
- empty  out  1  FIFO holds 0 words.
- level  out  CW  FIFO occupancy, 0..FIFO_DEPTH.
- busy  out  1  a frame is being shifted out (FSM state is not IDLE).
- overflow  out  1  sticky; set when a write is dropped.
- ovf_clr  in  1  clears `overflow` (write-1 pulse).
- uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset: one clock, `clk`. Reset is asynchronous, active-low on `rst_n`. While `rst_n`=0:
  - `uart_tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0.
  - FIFO pointers, baud counter and bit counter are 0; FSM is in IDLE.
  - Reset mid-frame abandons the frame. `uart_tx` returns to 1 asynchronously and the FIFO contents are discarded.
- FIFO:
  - A write is accepted when `wr_en`=1 and `full`=0 at the sampling edge. `level` increments the next cycle.
  - `wr_en`=1 while `full`=1 drops the word and sets `overflow` at the next edge. This applies even if a pop occurs in the same cycle.
  - `full`, `empty` and `level` are registered and derived from the pointers. Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
  - A simultaneous accepted write and pop leaves `level` unchanged.
  - If `ovf_clr` and a new overflow event occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, PARITY (only when the feature is compiled in), STOP.
  - IDLE: if `empty`=0, pop the head word into the shift register, clear the baud counter and go to START. Popping from an empty FIFO never occurs.
  - START: `uart_tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: send DATA_BITS bits LSB first, each held for CLK_DIV cycles. After the last bit go to PARITY (if enabled), otherwise STOP.
  - PARITY: send one parity bit for CLK_DIV cycles, then go to STOP.
  - STOP: `uart_tx`=1 for STOP_BITS*CLK_DIV cycles. At the end, if `empty`=0, pop the next word and go directly to START (no idle cycle). Otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1; a bit boundary occurs on the terminal count.
- `uart_tx` is driven from a register, so it is glitch-free.
- Latency: a write accepted at edge N into an empty FIFO with the FSM in IDLE gives pop at edge N+1. `uart_tx` falls at edge N+1 and stays low for CLK_DIV cycles.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) * CLK_DIV cycles, where P=1 with parity compiled in and P=0 without.
- `busy`=1 from the pop edge until the edge that returns the FSM to IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined, the PARITY state exists and adds parameter PARITY_ODD (default 0).
  - Parity bit = XOR of the payload bits, inverted when PARITY_ODD=1.
- When undefined, there is no PARITY state, no parity logic and no PARITY_ODD parameter. The frame goes straight from DATA to STOP.

Test Plan:
- Reset and idle: hold `rst_n`=0 for 3 cycles, then release. Expect `uart_tx`=1, `empty`=1, `level`=0 and `busy`=0, stable for 50 cycles.
- Single frame (defaults, no parity): write 0x55. Expect `uart_tx` sequence 0,1,0,1,0,1,0,1,0,1 with each bit 4 cycles (40 cycles total), the fall one edge after the write, then `busy`=0.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles. Expect `level` to peak at 2, three contiguous 40-cycle frames with no high gap beyond the stop bit, and then `empty`=1.
- Overflow: with FIFO_DEPTH=4, write 6 words in 6 consecutive cycles. Expect 5 accepted (the first is popped immediately), 1 dropped and `overflow`=1. Pulse `ovf_clr` and expect `overflow`=0. Expect 5 frames sent.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0, STOP_BITS=2): write 0x07. Expect the parity bit to be 1. Expect the frame to be 12 bits = 48 cycles, with the stop portion high for 8 cycles.
- Reset mid-frame: assert `rst_n`=0 during the DATA state of the 2nd of 3 queued frames. Expect `uart_tx`=1 immediately. After release, expect no further frames and `level`=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter fed by an internal transmit FIFO. Words written by the CPU
//   are queued and framed as: start bit, DATA_BITS payload bits (LSB first),
//   optional parity bit, STOP_BITS stop bits. Each bit lasts CLK_DIV clocks.
//   While the FIFO holds data, frames are sent back-to-back with no idle gap.
//
// Optional feature:
//   `define UART_TX_PARITY_EN adds a PARITY state and parameter PARITY_ODD
//   (0 = even parity, 1 = odd parity). Without the macro no parity logic exists.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wr_en     in   write strobe, one word per cycle
//   wr_data   in   word to enqueue [DATA_BITS]
//   full      out  FIFO holds FIFO_DEPTH words
//   empty     out  FIFO holds no words
//   level     out  FIFO occupancy 0..FIFO_DEPTH [CW]
//   busy      out  a frame is being shifted out
//   overflow  out  sticky, set when a write is dropped
//   ovf_clr   in   write-1 pulse clearing overflow (a same-cycle set wins)
//   uart_tx   out  serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
`ifdef UART_TX_PARITY_EN
  parameter bit PARITY_ODD = 1'b0,
`endif
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        level,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 ovf_clr,
  output logic                 uart_tx
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BDW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);
  localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        wr_ptr_d, rd_ptr_d, level_d;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign push = wr_en && !full;
  assign head = mem[rd_ptr[AW-1:0]];

  // Flags are registered from the next pointer values so they line up with the
  // pointers on every edge; the extra pointer MSB separates full from empty.
  always_comb begin
    wr_ptr_d = push ? wr_ptr + CW'(1) : wr_ptr;
    rd_ptr_d = pop  ? rd_ptr + CW'(1) : rd_ptr;
    level_d  = wr_ptr_d - rd_ptr_d;
  end

  // NOTE: every clocked block uses non-blocking assignments so all flops sample
  // the pre-edge values and the result does not depend on evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      level  <= level_d;
      full   <= (level_d == DEPTH_CNT);
      empty  <= (level_d == '0);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, so resetting them discards the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // A dropped write sets the flag even if the clear pulse arrives together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
    else if (ovf_clr)        overflow <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t               state, state_d;
  logic [BDW-1:0]       baud_cnt, baud_d;
  logic [BCW-1:0]       bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign baud_last = (baud_cnt == BAUD_LAST);

  // tx_d is the line value for the cycle after the edge, so uart_tx comes
  // straight from a flop and falls on the same edge that pops the word.
  // NOTE: every output of this block is given a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state != S_IDLE) baud_d = baud_last ? '0 : baud_cnt + BDW'(1);

    case (state)
      S_IDLE: begin
        if (!empty) pop = 1'b1;
      end

      S_START: begin
        if (baud_last) begin
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          if (bit_cnt == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_cnt + BCW'(1);
            tx_d    = shift_q[1];
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (baud_last) begin
          if (bit_cnt == STOP_LAST) begin
            bit_d = '0;
            if (!empty) pop = 1'b1;
            else        state_d = S_IDLE;
          end else begin
            bit_d = bit_cnt + BCW'(1);
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Popping loads the next frame and starts it without an idle cycle.
    if (pop) begin
      shift_d = head;
      baud_d  = '0;
      bit_d   = '0;
      tx_d    = 1'b0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Words written are pushed to an
//   expected-word queue; a line monitor rebuilds each frame from uart_tx and
//   the scenario tasks pop and compare. With UART_TX_PARITY_EN defined the
//   DUT is built with STOP_BITS=2, PARITY_ODD=0 and a parity scenario runs.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam int STOP_BITS  = 2;
  localparam int P          = 1;
  localparam bit PARITY_ODD = 1'b0;
`else
  localparam int STOP_BITS  = 1;
  localparam int P          = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_BITS + P + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 full, empty, busy, overflow, uart_tx;
  logic                 ovf_clr;
  logic [CW-1:0]        level;

  uart_tx_fifo #(
    .CLK_DIV    (CLK_DIV),
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
`ifdef UART_TX_PARITY_EN
    .PARITY_ODD (PARITY_ODD),
`endif
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DATA_BITS-1:0] word;
    logic                 par;
    bit                   ok;     // start low, bits stable, stop bits high
    int                   start;  // cycle count at first start-bit sample
  } rx_t;

  logic [DATA_BITS-1:0] exp_q [$];
  rx_t                  rx_log [64];
  int                   rx_count = 0;
  int                   rx_rd    = 0;
  int                   n_tests  = 0;
  int                   n_fail   = 0;

  function automatic rx_t decode(input logic [FRAME_CYC-1:0] s, input int t0);
    rx_t r;
    r.ok    = 1'b1;
    r.start = t0;
    r.word  = '0;
    for (int b = 0; b < FRAME_BITS; b++)
      for (int k = 1; k < CLK_DIV; k++)
        if (s[b*CLK_DIV+k] !== s[b*CLK_DIV]) r.ok = 1'b0;
    if (s[0] !== 1'b0) r.ok = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) r.word[i] = s[(1+i)*CLK_DIV];
    r.par = s[(1+DATA_BITS)*CLK_DIV];
    for (int b = 1 + DATA_BITS + P; b < FRAME_BITS; b++)
      if (s[b*CLK_DIV] !== 1'b1) r.ok = 1'b0;
    return r;
  endfunction

  // Line monitor: one sample per clock, on the falling edge.
  logic [FRAME_CYC-1:0] mon_sr = '0;
  int                   mon_n  = 0;
  int                   mon_t0 = 0;
  bit                   mon_active = 1'b0;

  always @(negedge clk) begin : monitor
    logic [FRAME_CYC-1:0] s;
    if (rst_n !== 1'b1) begin
      mon_active <= 1'b0;
      mon_n      <= 0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active <= 1'b1;
        mon_n      <= 1;
        mon_sr     <= '0;
        mon_t0     <= cyc;
      end
    end else begin
      s        = mon_sr;
      s[mon_n] = uart_tx;
      if (mon_n == FRAME_CYC - 1) begin
        if (rx_count < 64) rx_log[rx_count] <= decode(s, mon_t0);
        rx_count   <= rx_count + 1;
        mon_active <= 1'b0;
      end else begin
        mon_sr <= s;
        mon_n  <= mon_n + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic wait_frames(input int n, output bit timed_out);
    int target = rx_rd + n;
    timed_out = 1'b1;
    for (int i = 0; i < (n + 2) * FRAME_CYC; i++) begin
      if (rx_count >= target) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic next_frame(output rx_t f, output logic [DATA_BITS-1:0] e);
    f = rx_log[rx_rd];
    rx_rd++;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
  endtask

  task automatic resync();
    exp_q.delete();
    rx_rd = rx_count;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [CW+4:0] obs;
    logic [CW+4:0] req;
    int bad = 0;
    req = {1'b1, 1'b0, 1'b1, 1'b0, {CW{1'b0}}, 1'b0};
    repeat (3) begin
      @(negedge clk);
      obs = {uart_tx, busy, empty, full, level, overflow};
      n_tests++;
      if (obs !== req) begin
        n_fail++;
        $display("FAIL reset_hold: {tx,busy,empty,full,level,ovf}=%b required %b", obs, req);
      end
    end
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      obs = {uart_tx, busy, empty, full, level, overflow};
      if (obs !== req) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_stable: %0d of 50 idle cycles differed from %b", bad, req);
    end
  endtask

  task automatic test_single_frame();
    int c0;
    bit to;
    rx_t f;
    logic [DATA_BITS-1:0] e;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55; c0 = cyc;
    exp_q.push_back(8'h55);
    @(negedge clk);
    wr_en = 1'b0;
    n_tests++;
    if (uart_tx !== 1'b1 || level !== CW'(1) || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write_edge: tx=%b level=%0d empty=%b required tx=1 level=1 empty=0",
               uart_tx, level, empty);
    end
    @(negedge clk);
    n_tests++;
    if (uart_tx !== 1'b0 || busy !== 1'b1 || level !== CW'(0) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pop_edge: tx=%b busy=%b level=%0d empty=%b required tx=0 busy=1 level=0 empty=1",
               uart_tx, busy, level, empty);
    end
    repeat (FRAME_CYC - 1) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_last_cycle: busy=%b tx=%b required busy=1 tx=1", busy, uart_tx);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || uart_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: busy=%b tx=%b required busy=0 tx=1", busy, uart_tx);
    end
    wait_frames(1, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL single_timeout: frames seen %0d required %0d", rx_count, rx_rd + 1);
      resync();
    end else begin
      next_frame(f, e);
      n_tests++;
      if (f.word !== e || !f.ok || f.start !== c0 + 2) begin
        n_fail++;
        $display("FAIL single_frame: word=%h ok=%0d start=%0d required word=%h ok=1 start=%0d",
                 f.word, f.ok, f.start, e, c0 + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    int prev = 0;
    bit to;
    rx_t f;
    logic [DATA_BITS-1:0] e;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      wr_en = 1'b1; wr_data = DATA_BITS'(i + 1);
      exp_q.push_back(DATA_BITS'(i + 1));
    end
    repeat (4) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (int'(level) > peak) peak = int'(level);
    end
    n_tests++;
    if (peak !== 2) begin
      n_fail++;
      $display("FAIL b2b_peak_level: peak=%0d required 2", peak);
    end
    wait_frames(3, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL b2b_timeout: frames seen %0d required %0d", rx_count, rx_rd + 3);
      resync();
    end else begin
      for (int i = 0; i < 3; i++) begin
        next_frame(f, e);
        n_tests++;
        if (f.word !== e || !f.ok) begin
          n_fail++;
          $display("FAIL b2b_frame%0d: word=%h ok=%0d required word=%h ok=1", i, f.word, f.ok, e);
        end
        if (i > 0) begin
          n_tests++;
          if (f.start - prev !== FRAME_CYC) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: start spacing=%0d required %0d", i, f.start - prev, FRAME_CYC);
          end
        end
        prev = f.start;
      end
    end
    n_tests++;
    if (empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drained: empty=%b busy=%b required empty=1 busy=0", empty, busy);
    end
  endtask

  task automatic test_overflow();
    int prev = 0;
    bit to;
    rx_t f;
    logic [DATA_BITS-1:0] e;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_initial: overflow=%b required 0", overflow);
    end
    // Six writes on consecutive cycles; the clear pulse rides on the dropped
    // write so the set must win.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = DATA_BITS'(8'h10 + i);
      ovf_clr = (i == 5);
      if (i < 5) exp_q.push_back(DATA_BITS'(8'h10 + i));
    end
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b1 || full !== 1'b1 || level !== CW'(FIFO_DEPTH)) begin
      n_fail++;
      $display("FAIL ovf_set: overflow=%b full=%b level=%0d required overflow=1 full=1 level=%0d",
               overflow, full, level, FIFO_DEPTH);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: overflow=%b required 0", overflow);
    end
    wait_frames(5, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL ovf_timeout: frames seen %0d required %0d", rx_count, rx_rd + 5);
      resync();
    end else begin
      for (int i = 0; i < 5; i++) begin
        next_frame(f, e);
        n_tests++;
        if (f.word !== e || !f.ok) begin
          n_fail++;
          $display("FAIL ovf_frame%0d: word=%h ok=%0d required word=%h ok=1", i, f.word, f.ok, e);
        end
        if (i > 0) begin
          n_tests++;
          if (f.start - prev !== FRAME_CYC) begin
            n_fail++;
            $display("FAIL ovf_gap%0d: start spacing=%0d required %0d", i, f.start - prev, FRAME_CYC);
          end
        end
        prev = f.start;
      end
    end
    @(negedge clk);
    n_tests++;
    if (empty !== 1'b1 || level !== CW'(0) || full !== 1'b0 || rx_count !== rx_rd) begin
      n_fail++;
      $display("FAIL ovf_drained: empty=%b level=%0d full=%b extra frames=%0d required 1/0/0/0",
               empty, level, full, rx_count - rx_rd);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit to;
    rx_t f;
    logic [DATA_BITS-1:0] e;
    logic [DATA_BITS-1:0] w = 8'h07;
    logic exp_par;
    exp_par = (^w) ^ PARITY_ODD;
    @(negedge clk);
    wr_en = 1'b1; wr_data = w;
    exp_q.push_back(w);
    @(negedge clk);
    wr_en = 1'b0;
    wait_frames(1, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL parity_timeout: frames seen %0d required %0d", rx_count, rx_rd + 1);
      resync();
    end else begin
      next_frame(f, e);
      n_tests++;
      if (f.word !== e || !f.ok || f.par !== exp_par) begin
        n_fail++;
        $display("FAIL parity_frame: word=%h ok=%0d par=%b required word=%h ok=1 par=%b",
                 f.word, f.ok, f.par, e, exp_par);
      end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    bit to;
    rx_t f;
    logic [DATA_BITS-1:0] e;
    int t2;
    int rc;
    int bad = 0;
    logic [DATA_BITS-1:0] words [3];
    words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'hC3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = words[i];
    end
    exp_q.push_back(words[0]);
    @(negedge clk);
    wr_en = 1'b0;
    wait_frames(1, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL rstmid_timeout: frames seen %0d required %0d", rx_count, rx_rd + 1);
      resync();
      return;
    end
    next_frame(f, e);
    n_tests++;
    if (f.word !== e || !f.ok) begin
      n_fail++;
      $display("FAIL rstmid_frame0: word=%h ok=%0d required word=%h ok=1", f.word, f.ok, e);
    end
    // Second frame starts right after the first; aim at data bit 0 (a 0 for 0x5A).
    t2 = f.start + FRAME_CYC;
    for (int i = 0; i < 4 * FRAME_CYC; i++) begin
      if (cyc >= t2 + CLK_DIV + 1) break;
      @(negedge clk);
    end
    n_tests++;
    if (uart_tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_data: tx=%b busy=%b required tx=0 busy=1", uart_tx, busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || level !== CW'(0) || empty !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: tx=%b busy=%b level=%0d empty=%b full=%b required 1/0/0/1/0",
               uart_tx, busy, level, empty, full);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = rx_count;
    repeat (3 * FRAME_CYC) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || level !== CW'(0) || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || rx_count !== rc) begin
      n_fail++;
      $display("FAIL rstmid_after: %0d non-idle cycles, %0d new frames, required 0 and 0",
               bad, rx_count - rc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    ovf_clr = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
